// File: rtl/pad_in_filter.sv
// Pad input conditioning: 2-flop sync, consecutive-cycle debounce, edge pulses, sticky edge events.
// Optional sticky event logic is compiled in when PAD_IN_FILTER_EVENT_EN is defined.

module pad_in_filter_lane #(
  parameter int CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            pad_i,
  input  logic            en_i,
  input  logic [CntW-1:0] thresh_i,
  input  logic            clr_i,
  output logic            filt_o,
  output logic            rise_o,
  output logic            fall_o,
  output logic            event_o
);

  logic            r_s1, r_s2, r_filt, r_rise, r_fall;
  logic [CntW-1:0] r_cnt;
  logic            w_filt_d;
  logic [CntW-1:0] w_cnt_d;
  logic            w_rise_d, w_fall_d;

  // cnt only increments while below thresh, so it can never wrap; >= handles a lowered threshold
  always_comb begin
    w_filt_d = r_filt;
    w_cnt_d  = '0;
    if (!en_i) begin
      w_filt_d = r_s2;
    end else if (r_s2 != r_filt) begin
      if (r_cnt >= thresh_i) w_filt_d = r_s2;
      else                   w_cnt_d  = r_cnt + 1'b1;
    end
  end

  assign w_rise_d =  w_filt_d & ~r_filt;
  assign w_fall_d = ~w_filt_d &  r_filt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_filt <= 1'b0;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= pad_i;
      r_s2   <= r_s1;
      r_filt <= w_filt_d;
      r_cnt  <= w_cnt_d;
      r_rise <= w_rise_d;
      r_fall <= w_fall_d;
    end
  end

  assign filt_o = r_filt;
  assign rise_o = r_rise;
  assign fall_o = r_fall;

`ifdef PAD_IN_FILTER_EVENT_EN
  logic r_event;

  // set is taken from the same edge that updates filt, so it wins over a coincident clear
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                    r_event <= 1'b0;
    else if (w_rise_d || w_fall_d)  r_event <= 1'b1;
    else if (clr_i)                 r_event <= 1'b0;
  end

  assign event_o = r_event;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_i;
  assign event_o      = 1'b0;
`endif

endmodule

module pad_in_filter #(
  parameter int NPads = 70,
  parameter int CntW  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NPads-1:0] pad_in_i,
  input  logic [NPads-1:0] filter_en_i,
  input  logic [CntW-1:0]  thresh_i,
  output logic [NPads-1:0] filt_o,
  output logic [NPads-1:0] rise_o,
  output logic [NPads-1:0] fall_o,
  output logic [NPads-1:0] event_o,
  input  logic [NPads-1:0] event_clr_i
);

  for (genvar i = 0; i < NPads; i++) begin : g_lane
    pad_in_filter_lane #(.CntW(CntW)) u_lane (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .pad_i    (pad_in_i[i]),
      .en_i     (filter_en_i[i]),
      .thresh_i (thresh_i),
      .clr_i    (event_clr_i[i]),
      .filt_o   (filt_o[i]),
      .rise_o   (rise_o[i]),
      .fall_o   (fall_o[i]),
      .event_o  (event_o[i])
    );
  end

endmodule

// File: tb/tb_pad_in_filter.sv
// Randomised + directed bench for pad_in_filter against a per-pad behavioural model.
module tb_pad_in_filter;
  localparam int NP = 70;
  localparam int CW = 16;
`ifdef PAD_IN_FILTER_EVENT_EN
  localparam bit EV = 1'b1;
`else
  localparam bit EV = 1'b0;
`endif
  localparam logic [NP-1:0] ONES = '1;
  localparam logic [NP-1:0] ZERO = '0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NP-1:0] pad, en, clr;
  logic [CW-1:0] thr;
  logic [NP-1:0] filt, rise, fall, evt;

  always #5 clk = ~clk;

  pad_in_filter #(.NPads(NP), .CntW(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .pad_in_i(pad), .filter_en_i(en), .thresh_i(thr),
    .filt_o(filt), .rise_o(rise), .fall_o(fall), .event_o(evt), .event_clr_i(clr)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [NP-1:0] act, input logic [NP-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: pad level is seen two cycles late; a filtered pad adopts the synced level once it
  // has disagreed for more than thresh consecutive cycles (counted as an unbounded int).
  logic [NP-1:0] m_d1, m_d2, m_f, m_r, m_fl, m_e;
  int            m_run [NP];
  bit            m_ok = 1'b0;

  always @(posedge clk) begin
    logic [NP-1:0] nf, ne;
    int            nrun [NP];
    if (!rst_n) begin
      m_d1 <= '0; m_d2 <= '0; m_f <= '0; m_r <= '0; m_fl <= '0; m_e <= '0;
      for (int i = 0; i < NP; i++) m_run[i] <= 0;
      m_ok <= 1'b1;
    end else begin
      nf = m_f;
      for (int i = 0; i < NP; i++) begin
        nrun[i] = 0;
        if (!en[i]) nf[i] = m_d2[i];
        else if (m_d2[i] != m_f[i]) begin
          if (m_run[i] >= int'(thr)) nf[i] = m_d2[i];
          else nrun[i] = m_run[i] + 1;
        end
      end
      ne = m_e;
      if (EV) ne = (nf != m_f) ? (m_e | (nf ^ m_f)) : m_e;
      if (EV) ne = (ne & ~clr) | (m_e & (nf ^ m_f)) | (ne & (nf ^ m_f));
      m_d1 <= pad; m_d2 <= m_d1; m_f <= nf;
      m_r  <= nf & ~m_f;
      m_fl <= ~nf & m_f;
      m_e  <= ne;
      for (int i = 0; i < NP; i++) m_run[i] <= nrun[i];
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("mdl_filt", filt, m_f);
      chk("mdl_rise", rise, m_r);
      chk("mdl_fall", fall, m_fl);
      chk("mdl_event", evt, m_e);
      chk("rise_and_fall", rise & fall, ZERO);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pad = '0; clr = '0;
    step(); step();
    rst_n = 1'b1;
  endtask

  logic ph [48];
  logic seen;

  initial begin
    rst_n = 1'b0; pad = '1; en = '1; clr = '0; thr = 16'd4;
    step(); step();
    chk("reset_filt", filt, ZERO);
    chk("reset_event", evt, ZERO);
    // held-high pads out of reset: filt rises on the 7th edge with thresh=4
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rel_filt", filt, (k >= 6) ? ONES : ZERO);
      chk("rel_rise", rise, (k == 6) ? ONES : ZERO);
      if (k == 6) chk("rel_event", evt, EV ? ONES : ZERO);
    end

    do_reset();
    thr = 16'd4;
    pad[5] = 1'b1; seen = 1'b0;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) pad[5] = 1'b0;
      step();
      seen |= rise[5];
    end
    chk("glitch_filt", {69'b0, filt[5]}, ZERO);
    chk("glitch_rise", {69'b0, seen}, ZERO);
    chk("glitch_event", {69'b0, evt[5]}, ZERO);

    pad[5] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("p5_hi_filt", {69'b0, filt[5]}, {69'b0, (k >= 6)});
      chk("p5_hi_rise", {69'b0, rise[5]}, {69'b0, (k == 6)});
    end
    pad[5] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("p5_lo_filt", {69'b0, filt[5]}, {69'b0, (k < 6)});
      chk("p5_lo_fall", {69'b0, fall[5]}, {69'b0, (k == 6)});
    end

    en[32] = 1'b0; thr = 16'd100;
    for (int k = 0; k < 40; k++) begin
      pad[32] = ((k / 4) % 2) == 1;
      ph[k] = pad[32];
      step();
      if (k >= 3) begin
        chk("byp_filt", {69'b0, filt[32]}, {69'b0, ph[k-2]});
        chk("byp_rise", {69'b0, rise[32]}, {69'b0, ph[k-2] & ~ph[k-3]});
        chk("byp_fall", {69'b0, fall[32]}, {69'b0, ~ph[k-2] & ph[k-3]});
      end
    end
    pad[32] = 1'b0;
    repeat (4) step();
    en[32] = 1'b1;

    // edge and clear on the same edge: set wins; clear on the following edge takes effect
    thr = 16'd0;
    pad[63] = 1'b1;
    step(); step();
    clr[63] = 1'b1;
    step();
    chk("p63_rise", {69'b0, rise[63]}, {69'b0, 1'b1});
    chk("p63_evt_set", {69'b0, evt[63]}, {69'b0, EV});
    step();
    chk("p63_evt_clr", {69'b0, evt[63]}, ZERO);
    clr[63] = 1'b0;
    pad[63] = 1'b0;
    repeat (4) step();

    // threshold lowered mid-count
    thr = 16'd200;
    pad[0] = 1'b1;
    for (int k = 0; k < 52; k++) step();
    chk("p0_midcnt", {69'b0, filt[0]}, ZERO);
    thr = 16'd10;
    step();
    chk("p0_lowered", {69'b0, filt[0]}, {69'b0, 1'b1});
    chk("p0_lowered_rise", {69'b0, rise[0]}, {69'b0, 1'b1});
    thr = 16'd200;
    pad[0] = 1'b0;
    repeat (20) step();
    chk("p0_counting", {69'b0, filt[0]}, {69'b0, 1'b1});
    rst_n = 1'b0;
    step();
    chk("midrst_filt", filt, ZERO);
    chk("midrst_rise", rise | fall, ZERO);
    rst_n = 1'b1;
    pad = '0; pad[0] = 1'b1; thr = 16'd3;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("postrst_filt", {69'b0, filt[0]}, {69'b0, (k == 5)});
    end

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(7) == 0)  pad[i] = ~pad[i];
        if ($urandom_range(63) == 0) en[i]  = ~en[i];
        clr[i] = ($urandom_range(15) == 0);
      end
      if ($urandom_range(149) == 0) thr = 16'($urandom_range(6));
      rst_n = ($urandom_range(599) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pad_in_filter.md
Name: pad_in_filter

Overview:
- Input-conditioning stage between the padring `pad_in` vector and the peripheral `cio_*_i` inputs of `top_chip_system`.
- Per pad: 2-flop synchronisation, then a programmable consecutive-cycle debounce filter, then registered edge pulses and sticky edge events.
- Removes metastability and glitches from GPIO, I2C, UART RX and USB sense pad inputs before any peripheral sees them.

Parameters:
- NPads, 70: number of pad inputs filtered.
- CntW, 16: width of the debounce counter and of the threshold input.

Ports:
- clk_i  input  1  filter clock.
- rst_ni  input  1  synchronous active-low reset.
- pad_in_i  input  NPads  raw pad inputs from the padring (asynchronous).
- filter_en_i  input  NPads  per-pad debounce enable; 0 = bypass (sync only).
- thresh_i  input  CntW  debounce threshold, shared by all pads, quasi-static.
- filt_o  output  NPads  filtered pad level, to peripheral inputs.
- rise_o  output  NPads  1-cycle pulse, filt_o went 0->1.
- fall_o  output  NPads  1-cycle pulse, filt_o went 1->0.
- event_o  output  NPads  sticky "any edge seen" flags.
- event_clr_i  input  NPads  per-pad clear of event_o.

Behaviour:
- Clocking/reset:
  - Single clock domain clk_i.
  - Reset is synchronous, active-low, on rst_ni.
  - All flops clear on the first clk_i edge sampled with rst_ni=0: sync stages, filt_q, cnt_q, rise/fall/event registers.
  - Reset values: filt_o=0, rise_o=0, fall_o=0, event_o=0.
- Synchroniser: s1 <= pad_in_i; s2 <= s1. s2 is the synchronised level.
- Per-pad debounce, filter_en_i[i]=1:
  - s2 == filt_q: cnt_q <= 0.
  - s2 != filt_q and cnt_q < thresh_i: cnt_q <= cnt_q+1.
  - s2 != filt_q and cnt_q >= thresh_i: filt_q <= s2; cnt_q <= 0.
  - cnt_q never wraps; the >= comparison covers thresh_i being lowered mid-count.
  - Any return of s2 to filt_q before the threshold discards progress (cnt_q <= 0).
  - Latency from a pad level settling before clk edge 0 to filt_o changing is 3+thresh_i edges. thresh_i=0 gives 3 edges.
- Bypass, filter_en_i[i]=0:
  - filt_q <= s2 every cycle; cnt_q <= 0; latency 3 edges.
  - Toggling filter_en_i mid-count: the count is dropped, no spurious edge.
- Edge pulses:
  - rise_o[i] and fall_o[i] are registered from the filt_q update.
  - They assert in the same cycle filt_o first shows the new level.
  - Each lasts exactly 1 cycle.
  - They are never both high.
- Sticky events:
  - event_o[i] sets on rise or fall of pad i.
  - event_clr_i[i] clears it next cycle.
  - A simultaneous edge and clear leaves event_o[i]=1 (set wins).
- Release from reset:
  - filt_o starts at 0.
  - A pad held high out of reset produces a rise_o pulse after 3+thresh_i cycles. Software must expect this.
- Pads sharing the pulse/event logic are fully independent; there is no cross-pad interaction.

Optional Feature:
- Macro: PAD_IN_FILTER_EVENT_EN.
- Defined: the event_o sticky registers and the event_clr_i logic are present as described above.
- Undefined: no event registers; event_o is tied to 0 and event_clr_i is ignored. filt_o, rise_o and fall_o are unaffected.

Test Plan:
- Reset with pad_in_i=all 1, thresh_i=4, filter_en=all 1, then release -> filt_o=0 for 6 cycles; filt_o=all 1 and rise_o=all 1 on cycle 7 only; event_o=all 1 (macro defined).
- Pad 5: glitch high for 3 cycles, thresh_i=4 -> filt_o[5] stays 0, no rise_o[5], event_o[5]=0.
- Pad 5: high held for 10 cycles, thresh_i=4 -> filt_o[5]=1 exactly 7 edges after the first sampled high; rise_o[5] pulses once. Then low -> fall_o[5] pulse 7 edges later.
- filter_en_i[32]=0, thresh_i=100, toggle pad 32 every 4 cycles -> filt_o[32] tracks the pad with 3-cycle delay; rise/fall pulse on each toggle.
- Pad 63 edge on the same cycle as event_clr_i[63]=1 -> event_o[63] remains 1. A clear one cycle later -> event_o[63]=0.
- Pad 0 mid-count at cnt=50 with thresh_i=200, lower thresh_i to 10 -> filt_o[0] updates on the next edge, no counter wrap. Then assert rst_ni=0 mid-count -> filt_o=0 and cnt cleared after one edge.
